friscv_dmem_arbiter: RTL and testbench

Two-port arbiter that shares the single-port data memory (DMEM) between the core load/store path (requester 0) and the debug/program-loader port (requester 1). It grants at most one access per cycle using round-robin priority. It supports a per-requester lock for uninterrupted access sequences and returns read data with the DMEM's one-cycle read latency. It sits between the core/debug masters and the DMEM instance.

---
 rtl/friscv_dmem_arbiter.sv | 127 ++++++++++++
 tb/tb_friscv_dmem_arbiter.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/friscv_dmem_arbiter.sv
// Purpose : round-robin arbiter sharing the single-port DMEM between core (req 0) and debug/loader (req 1), with per-requester lock.
// Latency : grant is combinational (0 cycles); read data valid one cycle after a read grant.
// Backpress: requesters hold req_i and payload until gnt_o; a locked owner blocks the other requester entirely.
module friscv_dmem_arbiter #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int NUM_REQ    = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [1:0]                req_i,
    input  logic [1:0]                we_i,
    input  logic [1:0]                lock_i,
    input  logic [2*ADDR_WIDTH-1:0]   addr_i,
    input  logic [2*DATA_WIDTH/8-1:0] be_i,
    input  logic [2*DATA_WIDTH-1:0]   wdata_i,
    output logic [1:0]                gnt_o,
    output logic [1:0]                rvalid_o,
    output logic [DATA_WIDTH-1:0]     rdata_o,
    output logic                      mem_en_o,
    output logic                      mem_we_o,
    output logic [ADDR_WIDTH-1:0]     mem_addr_o,
    output logic [DATA_WIDTH/8-1:0]   mem_be_o,
    output logic [DATA_WIDTH-1:0]     mem_wdata_o,
    input  logic [DATA_WIDTH-1:0]     mem_rdata_i
);

    localparam int BE_W = DATA_WIDTH / 8;

    // The arbitration logic is written for exactly two requesters.
    generate
        if (NUM_REQ != 2) begin : g_bad_num_req
            $error("friscv_dmem_arbiter supports NUM_REQ == 2 only");
        end
    endgenerate

    // Encoding chosen so bit 1 is the lock flag and bit 0 the lock owner.
    typedef enum logic [1:0] {
        UNLOCKED = 2'b00,
        LOCKED_0 = 2'b10,
        LOCKED_1 = 2'b11
    } state_t;

    state_t     state_q, state_d;
    logic       prio_q, prio_d;
    logic [1:0] rvalid_q, rvalid_d;
    logic       lock_q, owner_q;
    logic [1:0] gnt;

    assign lock_q  = state_q[1];
    assign owner_q = state_q[0];

    // Grant: locked owner only, otherwise single requester or round-robin tie-break.
    // Held at zero during reset so nothing reaches the DMEM while rst_n is low.
    always_comb begin
        gnt = 2'b00;
        if (rst_n) begin
            if (lock_q) begin
                gnt[owner_q] = req_i[owner_q];
            end else if (req_i == 2'b11) begin
                gnt[prio_q] = 1'b1;
            end else begin
                gnt = req_i;
            end
        end
    end

    // Memory mux: forward the granted requester's payload, zeros when idle.
    always_comb begin
        mem_en_o    = |gnt;
        mem_we_o    = 1'b0;
        mem_addr_o  = '0;
        mem_be_o    = '0;
        mem_wdata_o = '0;
        if (gnt[1]) begin
            mem_we_o    = we_i[1];
            mem_addr_o  = addr_i[ADDR_WIDTH +: ADDR_WIDTH];
            mem_be_o    = be_i[BE_W +: BE_W];
            mem_wdata_o = wdata_i[DATA_WIDTH +: DATA_WIDTH];
        end else if (gnt[0]) begin
            mem_we_o    = we_i[0];
            mem_addr_o  = addr_i[0 +: ADDR_WIDTH];
            mem_be_o    = be_i[0 +: BE_W];
            mem_wdata_o = wdata_i[0 +: DATA_WIDTH];
        end
    end

    // Next state: priority flips to the loser after a grant, lock follows lock_i of the owner.
    always_comb begin
        state_d  = state_q;
        prio_d   = prio_q;
        rvalid_d = gnt & ~we_i;
        if (|gnt) begin
            prio_d = gnt[0];
        end
        case (state_q)
            UNLOCKED: begin
                if (gnt[0] && lock_i[0]) begin
                    state_d = LOCKED_0;
                end else if (gnt[1] && lock_i[1]) begin
                    state_d = LOCKED_1;
                end
            end
            LOCKED_0: if (!lock_i[0]) state_d = UNLOCKED;
            LOCKED_1: if (!lock_i[1]) state_d = UNLOCKED;
            default:  state_d = UNLOCKED;
        endcase
    end

    // State registers; reset drops any lock and any read still in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= UNLOCKED;
            prio_q   <= 1'b0;
            rvalid_q <= 2'b00;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            rvalid_q <= rvalid_d;
        end
    end

    assign gnt_o    = gnt;
    assign rvalid_o = rvalid_q;
    assign rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_friscv_dmem_arbiter.sv
// Purpose : directed vector bench for friscv_dmem_arbiter with a behavioural one-cycle DMEM.
// Latency : each vector is one clock; outputs sampled 2 time units after the falling edge.
// Backpress: stimulus re-presents requests exactly as a well-behaved master would.
module tb_friscv_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  req_i, we_i, lock_i;
    logic [23:0] addr_i;
    logic [7:0]  be_i;
    logic [63:0] wdata_i;
    logic [1:0]  gnt_o, rvalid_o;
    logic [31:0] rdata_o;
    logic        mem_en_o, mem_we_o;
    logic [11:0] mem_addr_o;
    logic [3:0]  mem_be_o;
    logic [31:0] mem_wdata_o;
    logic [31:0] mem_rdata_i;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    friscv_dmem_arbiter #(.ADDR_WIDTH(12), .DATA_WIDTH(32), .NUM_REQ(2)) dut (
        .clk(clk), .rst_n(rst_n), .req_i(req_i), .we_i(we_i), .lock_i(lock_i),
        .addr_i(addr_i), .be_i(be_i), .wdata_i(wdata_i), .gnt_o(gnt_o),
        .rvalid_o(rvalid_o), .rdata_o(rdata_o), .mem_en_o(mem_en_o),
        .mem_we_o(mem_we_o), .mem_addr_o(mem_addr_o), .mem_be_o(mem_be_o),
        .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata_i)
    );

    // Behavioural single-port DMEM: byte-enabled writes, one-cycle reads.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_en_o) begin
            if (mem_we_o) begin
                for (int b = 0; b < 4; b++)
                    if (mem_be_o[b]) mem[mem_addr_o[11:2]][8*b +: 8] <= mem_wdata_o[8*b +: 8];
            end else begin
                mem_rdata_i <= mem[mem_addr_o[11:2]];
            end
        end
    end

    typedef struct {
        logic [1:0]  req, we, lock;
        logic [11:0] a0, a1;
        logic [3:0]  be0;
        logic [31:0] wd0;
        logic [1:0]  e_gnt;
        logic        e_we;
        logic [11:0] e_addr;
        logic [1:0]  e_rv;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t v [0:25];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [1:0] req, input logic [1:0] we, input logic [1:0] lock,
                         input logic [11:0] a0, input logic [11:0] a1,
                         input logic [3:0] be0, input logic [31:0] wd0);
        req_i   = req;
        we_i    = we;
        lock_i  = lock;
        addr_i  = {a1, a0};
        be_i    = {4'hF, be0};
        wdata_i = {32'h0, wd0};
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 32'h1000_0000 | i;
        mem[32'h080 >> 2] = 32'h1122_3344;
        mem_rdata_i = 32'h0;

        //        req    we     lock   a0       a1       be0    wd0            gnt    we    addr     rv     rdata
        v[0]  = '{2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b01, 1'b0, 12'h020, 2'b00, 32'h0};
        v[1]  = '{2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b01, 32'h1000_0008};
        v[2]  = '{2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b01, 1'b0, 12'h020, 2'b10, 32'h1000_0010};
        v[3]  = '{2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b01, 32'h1000_0008};
        v[4]  = '{2'b01, 2'b01, 2'b00, 12'h010, 12'h000, 4'hF, 32'hDEAD_BEEF, 2'b01, 1'b1, 12'h010, 2'b10, 32'h1000_0010};
        v[5]  = '{2'b01, 2'b00, 2'b00, 12'h010, 12'h000, 4'hF, 32'h0,         2'b01, 1'b0, 12'h010, 2'b00, 32'h0};
        v[6]  = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b01, 32'hDEAD_BEEF};
        v[7]  = '{2'b01, 2'b01, 2'b00, 12'h080, 12'h000, 4'h4, 32'h00AA_0000, 2'b01, 1'b1, 12'h080, 2'b00, 32'h0};
        v[8]  = '{2'b01, 2'b00, 2'b00, 12'h080, 12'h000, 4'hF, 32'h0,         2'b01, 1'b0, 12'h080, 2'b00, 32'h0};
        v[9]  = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b01, 32'h11AA_3344};
        v[10] = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b00, 32'h0};
        v[11] = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b00, 32'h0};
        v[12] = '{2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b00, 32'h0};
        v[13] = '{2'b10, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b10, 32'h1000_0010};
        v[14] = '{2'b11, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b10, 32'h1000_0010};
        v[15] = '{2'b11, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b10, 32'h1000_0010};
        v[16] = '{2'b11, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b10, 32'h1000_0010};
        v[17] = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b10, 32'h1000_0010};
        v[18] = '{2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b01, 1'b0, 12'h020, 2'b00, 32'h0};
        v[19] = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b01, 32'h1000_0008};
        v[20] = '{2'b10, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b10, 1'b0, 12'h040, 2'b00, 32'h0};
        v[21] = '{2'b01, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b00, 1'b0, 12'h000, 2'b10, 32'h1000_0010};
        v[22] = '{2'b00, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0,         2'b00, 1'b0, 12'h000, 2'b00, 32'h0};
        v[23] = '{2'b01, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b00, 1'b0, 12'h000, 2'b00, 32'h0};
        v[24] = '{2'b01, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0,         2'b01, 1'b0, 12'h020, 2'b00, 32'h0};
        v[25] = '{2'b00, 2'b00, 2'b00, 12'h000, 12'h000, 4'h0, 32'h0,         2'b00, 1'b0, 12'h000, 2'b01, 32'h1000_0008};

        // Reset with both requesting: nothing may be granted or reach the DMEM.
        rst_n = 1'b0;
        drive(2'b11, 2'b00, 2'b11, 12'h020, 12'h040, 4'hF, 32'h0);
        repeat (2) @(negedge clk);
        #2;
        check("rst_gnt", {30'h0, gnt_o}, 32'h0);
        check("rst_rvalid", {30'h0, rvalid_o}, 32'h0);
        check("rst_mem_en", {31'h0, mem_en_o}, 32'h0);
        check("rst_mem_addr", {20'h0, mem_addr_o}, 32'h0);
        check("rst_mem_wdata", mem_wdata_o, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drive(v[i].req, v[i].we, v[i].lock, v[i].a0, v[i].a1, v[i].be0, v[i].wd0);
            #2;
            check($sformatf("v%0d_gnt", i), {30'h0, gnt_o}, {30'h0, v[i].e_gnt});
            check($sformatf("v%0d_mem_en", i), {31'h0, mem_en_o}, {31'h0, |v[i].e_gnt});
            check($sformatf("v%0d_mem_we", i), {31'h0, mem_we_o}, {31'h0, v[i].e_we});
            check($sformatf("v%0d_mem_addr", i), {20'h0, mem_addr_o}, {20'h0, v[i].e_addr});
            check($sformatf("v%0d_rvalid", i), {30'h0, rvalid_o}, {30'h0, v[i].e_rv});
            if (v[i].e_rv != 2'b00)
                check($sformatf("v%0d_rdata", i), rdata_o, v[i].e_rdata);
            @(negedge clk);
        end

        // Asynchronous reset while LOCKED_1 with a read in flight.
        drive(2'b10, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0);
        #2;
        check("lk_gnt", {30'h0, gnt_o}, 32'h2);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b10, 12'h020, 12'h040, 4'hF, 32'h0);
        #2;
        check("lk_hold_gnt", {30'h0, gnt_o}, 32'h2);
        check("lk_rvalid", {30'h0, rvalid_o}, 32'h2);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_gnt", {30'h0, gnt_o}, 32'h0);
        check("arst_rvalid", {30'h0, rvalid_o}, 32'h0);
        check("arst_mem_en", {31'h0, mem_en_o}, 32'h0);
        @(negedge clk);
        drive(2'b11, 2'b00, 2'b00, 12'h020, 12'h040, 4'hF, 32'h0);
        rst_n = 1'b1;
        #2;
        check("post_rst_gnt", {30'h0, gnt_o}, 32'h1);
        check("post_rst_addr", {20'h0, mem_addr_o}, 32'h020);
        @(negedge clk);
        #2;
        check("post_rst_gnt2", {30'h0, gnt_o}, 32'h2);
        check("post_rst_rvalid", {30'h0, rvalid_o}, 32'h1);
        check("post_rst_rdata", rdata_o, 32'h1000_0008);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
